// File: rtl/bus_responder_if.sv
// -----------------------------------------------------------------------------
// bus_responder_if
// Purpose : CPU-side request strobes plus the memory-backend request/ack
//           handshake used by bus_responder.
// Signals : rd, wr, addr, wdata          CPU request (level strobes + payload)
//           mem_req, mem_we, mem_addr,
//           mem_wdata                    backend request, held until ack/timeout
//           mem_ack, mem_rdata           backend acknowledge and read data
//           cpu_data, cpu_wait,
//           data_valid, bus_err          CPU-facing status and returned byte
// Modports: slave  = the responder, master = the CPU/backend side driving it.
// -----------------------------------------------------------------------------
interface bus_responder_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_ack;
    logic [7:0]        mem_rdata;
    logic [7:0]        cpu_data;
    logic              cpu_wait;
    logic              data_valid;
    logic              bus_err;

    modport slave (
        input  rd, wr, addr, wdata, mem_ack, mem_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output cpu_data, cpu_wait, data_valid, bus_err
    );

    modport master (
        output rd, wr, addr, wdata, mem_ack, mem_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  cpu_data, cpu_wait, data_valid, bus_err
    );
endinterface

// File: rtl/bus_responder.sv
// -----------------------------------------------------------------------------
// bus_responder
// Purpose : Turns a CPU rd/wr rising edge into one request/acknowledge transfer
//           on the memory backend, then holds the returned byte on cpu_data
//           until the next read. A backend that never acknowledges is cut off
//           after TIMEOUT cycles and reads return OPEN_BUS.
// Ports   : clk        system clock, rising edge
//           rst        asynchronous reset, active-high
//           bus        bus_responder_if.slave (CPU strobes, backend handshake,
//                      cpu_data / cpu_wait / data_valid / bus_err)
// -----------------------------------------------------------------------------
module bus_responder #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned TIMEOUT  = 15,
    parameter logic [7:0]  OPEN_BUS = 8'hFF
) (
    input  logic            clk,
    input  logic            rst,
    bus_responder_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_rd_q;
    logic              r_wr_q;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_mem_wdata;
    logic [7:0]        r_cpu_data;
    logic              r_cpu_wait;
    logic              r_data_valid;
    logic              r_bus_err;

    logic              w_rd_edge;
    logic              w_wr_edge;
    logic              w_last;

    assign w_rd_edge = bus.rd & ~r_rd_q;
    assign w_wr_edge = bus.wr & ~r_wr_q;
    assign w_last    = (r_cnt == CNT_W'(TIMEOUT - 1));

    // Single-process FSM: IDLE -> REQ -> DONE -> IDLE, all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_rd_q       <= 1'b0;
            r_wr_q       <= 1'b0;
            r_cnt        <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= 8'h00;
            r_cpu_data   <= 8'h00;
            r_cpu_wait   <= 1'b0;
            r_data_valid <= 1'b0;
            r_bus_err    <= 1'b0;
        end else begin
            r_rd_q    <= bus.rd;
            r_wr_q    <= bus.wr;
            r_bus_err <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    // Read has priority; a simultaneous write edge is dropped and flagged.
                    if (w_rd_edge) begin
                        r_mem_addr <= bus.addr;
                        r_mem_we   <= 1'b0;
                        r_mem_req  <= 1'b1;
                        r_cpu_wait <= 1'b1;
                        r_cnt      <= '0;
                        r_bus_err  <= w_wr_edge;
                        r_state    <= S_REQ;
                    end else if (w_wr_edge) begin
                        r_mem_addr  <= bus.addr;
                        r_mem_wdata <= bus.wdata;
                        r_mem_we    <= 1'b1;
                        r_mem_req   <= 1'b1;
                        r_cpu_wait  <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= S_REQ;
                    end
                end

                S_REQ: begin
                    // An ack on the final cycle still wins over the timeout.
                    if (bus.mem_ack) begin
                        r_mem_req    <= 1'b0;
                        r_cpu_wait   <= 1'b0;
                        r_data_valid <= 1'b1;
                        if (!r_mem_we) begin
                            r_cpu_data <= bus.mem_rdata;
                        end
                        r_state <= S_DONE;
                    end else if (w_last) begin
                        r_mem_req    <= 1'b0;
                        r_cpu_wait   <= 1'b0;
                        r_data_valid <= 1'b1;
                        r_bus_err    <= 1'b1;
                        if (!r_mem_we) begin
                            r_cpu_data <= OPEN_BUS;
                        end
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                S_DONE: begin
                    // Hold the result until the CPU drops both strobes.
                    if (!bus.rd && !bus.wr) begin
                        r_data_valid <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req    = r_mem_req;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.cpu_data   = r_cpu_data;
    assign bus.cpu_wait   = r_cpu_wait;
    assign bus.data_valid = r_data_valid;
    assign bus.bus_err    = r_bus_err;
endmodule

// File: tb/tb_bus_responder.sv
// -----------------------------------------------------------------------------
// tb_bus_responder
// Purpose : Self-checking bench for bus_responder. A table of transfers is
//           driven through a CPU/backend model; expected results are queued at
//           drive time and compared when data_valid appears. Hand-written
//           sequences cover reset, stray acks, overlapping edges and reset
//           during a transfer.
// -----------------------------------------------------------------------------
module tb_bus_responder;
    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned TIMEOUT = 15;

    typedef struct {
        bit          is_wr;
        bit          coll;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        int          ack_at;    // REQ cycle (1-based) carrying mem_ack; 0 = never
        int          hold;      // extra cycles the strobe stays high in DONE
        logic [7:0]  exp_data;
        int          exp_err;
        int          exp_wait;
        int          exp_lat;
        bit          exp_we;
    } vec_t;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;
    vec_t vecs[8];
    vec_t sb_q[$];

    bus_responder_if #(.ADDR_W(ADDR_W)) bus ();

    bus_responder #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT),
        .OPEN_BUS(8'hFF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one transfer, model the backend, then score it against the queue.
    task automatic run_txn(input vec_t v);
        int          lat;
        int          waitc;
        int          errc;
        int          reqc;
        bit          done;
        logic [15:0] cap_addr;
        logic        cap_we;
        logic [7:0]  cap_wd;
        vec_t        e;
        logic [7:0]  held;

        @(negedge clk);
        bus.addr  = v.addr;
        bus.wdata = v.wdata;
        if (v.is_wr && !v.coll) bus.wr = 1'b1;
        else                    bus.rd = 1'b1;
        if (v.coll) bus.wr = 1'b1;
        sb_q.push_back(v);

        lat = 0; waitc = 0; errc = 0; reqc = 0; done = 1'b0;
        cap_addr = '0; cap_we = 1'b0; cap_wd = '0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            lat++;
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = 8'hCC;
            if (c == 0) begin
                bus.addr  = ~v.addr;
                bus.wdata = ~v.wdata;
            end
            if (bus.bus_err)  errc++;
            if (bus.cpu_wait) waitc++;
            if (bus.data_valid) begin
                done = 1'b1;
            end else if (bus.mem_req) begin
                reqc++;
                cap_addr = bus.mem_addr;
                cap_we   = bus.mem_we;
                cap_wd   = bus.mem_wdata;
                if (reqc == v.ack_at) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = v.rdata;
                end
            end
        end

        if (!done) begin
            chk("txn_done_budget", 0, 1);
            void'(sb_q.pop_front());
        end else if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
        end else begin
            e = sb_q.pop_front();
            chk("cpu_data",  int'(bus.cpu_data), int'(e.exp_data));
            chk("bus_err",   errc,               e.exp_err);
            chk("cpu_wait",  waitc,              e.exp_wait);
            chk("latency",   lat,                e.exp_lat);
            chk("mem_addr",  int'(cap_addr),     int'(e.addr));
            chk("mem_we",    int'(cap_we),       int'(e.exp_we));
            if (e.exp_we) chk("mem_wdata", int'(cap_wd), int'(e.wdata));
        end

        held = bus.cpu_data;
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            chk("dv_hold",   int'(bus.data_valid), 1);
            chk("data_hold", int'(bus.cpu_data),   int'(held));
        end

        bus.rd = 1'b0;
        bus.wr = 1'b0;
        @(negedge clk);
        chk("dv_release",   int'(bus.data_valid), 0);
        chk("wait_release", int'(bus.cpu_wait),   0);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;

        //          wr coll addr      wdata  rdata  ack hold data  err wait lat we
        vecs[0] = '{0, 0, 16'h0150, 8'h00, 8'h3E, 1,  3,   8'h3E, 0, 1,  2,  0};
        vecs[1] = '{1, 0, 16'hC000, 8'h5A, 8'hEE, 4,  0,   8'h3E, 0, 4,  5,  1};
        vecs[2] = '{0, 0, 16'hFEA0, 8'h00, 8'h00, 0,  0,   8'hFF, 1, 15, 16, 0};
        vecs[3] = '{0, 0, 16'hFEA0, 8'h00, 8'h77, 15, 0,   8'h77, 0, 15, 16, 0};
        vecs[4] = '{1, 1, 16'h1234, 8'h99, 8'hA5, 2,  1,   8'hA5, 1, 2,  3,  0};
        vecs[5] = '{1, 0, 16'h0001, 8'h11, 8'hEE, 1,  0,   8'hA5, 0, 1,  2,  1};
        vecs[6] = '{1, 0, 16'h2222, 8'h33, 8'hEE, 0,  0,   8'hA5, 1, 15, 16, 1};
        vecs[7] = '{0, 0, 16'h0002, 8'h00, 8'h42, 3,  0,   8'h42, 0, 3,  4,  0};

        bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.wdata = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_mem_req",  int'(bus.mem_req),    0);
        chk("rst_cpu_data", int'(bus.cpu_data),   0);
        chk("rst_wait",     int'(bus.cpu_wait),   0);
        chk("rst_dv",       int'(bus.data_valid), 0);
        chk("rst_err",      int'(bus.bus_err),    0);
        chk("rst_mem_addr", int'(bus.mem_addr),   0);
        rst = 1'b0;
        @(negedge clk);

        // Stray ack in IDLE must not touch anything.
        bus.mem_ack = 1'b1; bus.mem_rdata = 8'h55;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk("stray_cpu_data", int'(bus.cpu_data),   0);
        chk("stray_mem_req",  int'(bus.mem_req),    0);
        chk("stray_dv",       int'(bus.data_valid), 0);

        // Table; consecutive entries also exercise back-to-back strobes.
        for (int i = 0; i < 8; i++) run_txn(vecs[i]);

        // Second rd edge inside REQ is ignored and not queued.
        @(negedge clk);
        bus.addr = 16'h0300; bus.rd = 1'b1;
        @(negedge clk);
        chk("ovl_req", int'(bus.mem_req), 1);
        bus.addr = 16'h0000; bus.rd = 1'b0;
        @(negedge clk);
        bus.rd = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b1; bus.mem_rdata = 8'h6B;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk("ovl_dv",   int'(bus.data_valid), 1);
        chk("ovl_data", int'(bus.cpu_data),   8'h6B);
        chk("ovl_addr", int'(bus.mem_addr),   16'h0300);
        repeat (2) @(negedge clk);
        chk("ovl_dv_held", int'(bus.data_valid), 1);
        bus.rd = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ovl_no_requeue", int'(bus.mem_req) | int'(bus.data_valid), 0);
        end

        // Asynchronous reset in the middle of REQ.
        bus.addr = 16'h4444; bus.rd = 1'b1;
        @(negedge clk);
        chk("mid_req", int'(bus.mem_req), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_mem_req",  int'(bus.mem_req),  0);
        chk("arst_cpu_data", int'(bus.cpu_data), 0);
        chk("arst_wait",     int'(bus.cpu_wait), 0);
        chk("arst_mem_addr", int'(bus.mem_addr), 0);
        bus.rd = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_req", int'(bus.mem_req),    0);
        chk("post_rst_dv",  int'(bus.data_valid), 0);

        chk("scoreboard_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
